// File: rtl/impl_window_checker.sv
// impl_window_checker: per-channel bounded-window implication checker.
// Each channel tracks overlapping antecedent attempts (a_i) and resolves them
// against the consequent (b_i) within MIN_DLY..MAX_DLY cycles.
// Optional statistics counters are enabled by defining IMPL_WINDOW_CHECKER_STATS_EN;
// without it pass_cnt_o/fail_cnt_o are tied to zero and no counter logic exists.
module impl_window_checker #(
  parameter  int NCH     = 4,
  parameter  int MIN_DLY = 1,
  parameter  int MAX_DLY = 1,
  parameter  int CNT_W   = 16,
  localparam int FFW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dis_i,
  input  logic             clr_i,
  input  logic [NCH-1:0]   a_i,
  input  logic [NCH-1:0]   b_i,
  output logic [NCH-1:0]   pass_o,
  output logic [NCH-1:0]   fail_o,
  output logic             err_o,
  output logic [FFW-1:0]   first_fail_ch_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  // Bit k of r_pend[c] = attempt launched k edges ago, still unresolved.
  logic [NCH-1:0][MAX_DLY:1] r_pend;
  logic [NCH-1:0][MAX_DLY:1] w_pend_nxt;
  logic [NCH-1:0]            w_pass_hit;
  logic [NCH-1:0]            w_fail_hit;
  logic [NCH-1:0]            w_pass_ev;
  logic [NCH-1:0]            w_fail_ev;
  logic [FFW-1:0]            w_first;
  logic [NCH-1:0]            r_pass;
  logic [NCH-1:0]            r_fail;
  logic                      r_err;
  logic [FFW-1:0]            r_ffc;

  // Resolve pending attempts against b_i and form the shifted pending vector.
  always_comb begin
    w_pass_hit = '0;
    w_fail_hit = '0;
    w_pend_nxt = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 1; k <= MAX_DLY; k++) begin
        if (k >= MIN_DLY && r_pend[c][k] && b_i[c]) w_pass_hit[c] = 1'b1;
      end
      w_fail_hit[c]    = ~b_i[c] & r_pend[c][MAX_DLY];
      w_pend_nxt[c][1] = a_i[c];
      // Attempts inside the window are consumed by b; older-than-MAX retire.
      for (int k = 1; k < MAX_DLY; k++) begin
        if (k >= MIN_DLY && b_i[c]) w_pend_nxt[c][k+1] = 1'b0;
        else                        w_pend_nxt[c][k+1] = r_pend[c][k];
      end
    end
    // A disabled edge produces no results at all.
    w_pass_ev = w_pass_hit & {NCH{~dis_i}};
    w_fail_ev = w_fail_hit & {NCH{~dis_i}};
  end

  // Lowest failing channel index at this edge.
  always_comb begin
    w_first = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_fail_ev[c]) w_first = FFW'(c);
    end
  end

  // Pending attempt state; disable and reset both abort everything in flight.
  always_ff @(posedge clk) begin
    if (rst || dis_i) r_pend <= '0;
    else              r_pend <= w_pend_nxt;
  end

  // Registered one-cycle pass/fail pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass <= '0;
      r_fail <= '0;
    end else begin
      r_pass <= w_pass_ev;
      r_fail <= w_fail_ev;
    end
  end

  // Sticky error and first-failing channel; a failure on a clear edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
      r_ffc <= '0;
    end else if (|w_fail_ev) begin
      r_err <= 1'b1;
      if (!r_err || clr_i) r_ffc <= w_first;
    end else if (clr_i) begin
      r_err <= 1'b0;
      r_ffc <= '0;
    end
  end

  assign pass_o          = r_pass;
  assign fail_o          = r_fail;
  assign err_o           = r_err;
  assign first_fail_ch_o = r_ffc;

`ifdef IMPL_WINDOW_CHECKER_STATS_EN
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  function automatic logic [5:0] popcnt(input logic [NCH-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                                input logic [5:0]       inc);
    logic [CNT_W+6:0] sum;
    sum = {7'd0, cur} + {{(CNT_W+1){1'b0}}, inc};
    if (sum > {7'd0, {CNT_W{1'b1}}}) return '1;
    return sum[CNT_W-1:0];
  endfunction

  // Saturating aggregate counters; clear restarts from zero at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_pass_cnt <= sat_add(clr_i ? '0 : r_pass_cnt, popcnt(w_pass_ev));
      r_fail_cnt <= sat_add(clr_i ? '0 : r_fail_cnt, popcnt(w_fail_ev));
    end
  end

  assign pass_cnt_o = r_pass_cnt;
  assign fail_cnt_o = r_fail_cnt;
`else
  assign pass_cnt_o = '0;
  assign fail_cnt_o = '0;
`endif

endmodule

// File: doc/impl_window_checker.md
IMPL_WINDOW_CHECKER -- requirements
Module: impl_window_checker

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent checker channels (1..32).
REQ-002 SHALL have parameter MIN_DLY, default 1, earliest consequent delay in cycles (>=1).
REQ-003 SHALL have parameter MAX_DLY, default 1, latest consequent delay in cycles (MIN_DLY..16); MIN_DLY=MAX_DLY=1 gives next-cycle implication.
REQ-004 SHALL have parameter CNT_W, default 16, width of pass/fail counters.
REQ-005 SHALL have port clk  input  1  single clock; all state samples on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port dis_i  input  1  disable; aborts all pending attempts.
REQ-008 SHALL have port clr_i  input  1  clears counters, sticky error and first-fail index.
REQ-009 SHALL have port a_i  input  NCH  per-channel antecedent.
REQ-010 SHALL have port b_i  input  NCH  per-channel consequent.
REQ-011 SHALL have port pass_o  output  NCH  one-cycle per-channel pass pulse.
REQ-012 SHALL have port fail_o  output  NCH  one-cycle per-channel fail pulse.
REQ-013 SHALL have port err_o  output  1  sticky "any failure since reset/clear".
REQ-014 SHALL have port first_fail_ch_o  output  $clog2(NCH) (min 1)  lowest channel index of the first failing edge.
REQ-015 SHALL have ports pass_cnt_o, fail_cnt_o  output  CNT_W  aggregate event counters.

Function
REQ-016 SHALL keep per channel a pending vector P[1..MAX_DLY]; bit k set = unresolved attempt launched k edges ago.
REQ-017 SHALL, at an edge with dis_i=0 and a_i[c]=1, launch an attempt visible as P[1] at the next edge; overlapping attempts SHALL each be tracked independently.
REQ-018 SHALL, at an edge with b_i[c]=1, resolve every set P[k] with MIN_DLY<=k<=MAX_DLY as passed; pass_o[c] high for the following cycle (single pulse regardless of attempts resolved).
REQ-019 SHALL, at an edge with b_i[c]=0 and P[MAX_DLY] set, declare failure; fail_o[c] high for the following cycle.
REQ-020 SHALL treat b_i[c]=1 at P[k], k<MIN_DLY, as no effect (attempt stays pending).
REQ-021 SHALL shift surviving bits P[k]->P[k+1] each edge; P[MAX_DLY] always retires.
REQ-022 pass_o[c] and fail_o[c] SHALL never be high in the same cycle.
REQ-023 SHALL, at an edge with dis_i=1, clear all P, launch nothing, and drive pass_o=fail_o=0 next cycle.
REQ-024 pass_cnt_o/fail_cnt_o SHALL increment by popcount of channels passing/failing at that edge, saturating at 2^CNT_W-1.
REQ-025 err_o SHALL set on first failure and hold until clr_i or rst; first_fail_ch_o SHALL latch only when err_o transitions 0->1.
REQ-026 clr_i SHALL take effect at its edge; a failure at the same edge SHALL win (err_o=1, counter=1 if that failure counts).
REQ-027 Output pulses SHALL be registered; combinational paths from inputs to outputs SHALL NOT exist.

Reset
REQ-028 At an edge with rst=1 SHALL clear all P, pass_o=0, fail_o=0, err_o=0, first_fail_ch_o=0, both counters 0; rst SHALL override dis_i and clr_i.
REQ-029 Attempts pending when rst asserts mid-window SHALL be discarded without pass or fail.

Configuration
REQ-030 With IMPL_WINDOW_CHECKER_STATS_EN defined SHALL implement pass_cnt_o/fail_cnt_o per REQ-024; undefined, both SHALL be tied to 0 and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 MIN=MAX=1: a_i[0]=1 edge 3, b_i[0]=1 edge 4 -> pass_o[0] pulse after edge 4, pass_cnt=1.
REQ-032 MIN=MAX=1: a_i[1]=1 edge 3, b_i[1]=0 edge 4 -> fail_o[1] pulse after edge 4, err_o=1, first_fail_ch_o=1.
REQ-033 MIN=2,MAX=4: a_i[0] edges 5,6; b_i[0] only edge 8 -> one pass pulse after edge 8 (both resolved), no fail.
REQ-034 MIN=2,MAX=4: a_i[0] edge 5, b_i[0] only edge 6 -> no pass; fail_o[0] after edge 9.
REQ-035 MIN=2,MAX=4: a_i[0] edge 5, dis_i=1 edge 7, b_i=0 -> no pass, no fail; same with rst=1 edge 7 -> all outputs 0.
REQ-036 CNT_W=2, STATS_EN: 5 passes -> pass_cnt_o=3 saturated; clr_i with simultaneous fail -> fail_cnt_o=1, err_o=1.
